// File: rtl/type_pkg.sv
// Shared types for the data-memory path: RAM bus widths, LSU access size and LSU state.
package type_pkg;

  localparam int MEM_AW = 10;

  typedef logic [31:0]       MemBus;
  typedef logic [MEM_AW-1:0] MemAddrBus;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'b00,
    LSU_HALF = 2'b01,
    LSU_WORD = 2'b10,
    LSU_RSVD = 2'b11
  } LsuSize_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } LsuState_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: store merge into a RAM word and load extract/extend.
module lsu_align
  import type_pkg::*;
(
  input  MemBus       i_word,
  input  logic [31:0] i_wdata,
  input  LsuSize_e    i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  output MemBus       o_merged,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_merged = i_word;
    case (i_size)
      LSU_BYTE: begin
        case (i_lane)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      LSU_HALF: begin
        if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

  always_comb begin
    w_byte  = 8'h00;
    w_half  = 16'h0000;
    o_rdata = i_word;
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    case (i_size)
      LSU_BYTE: o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      LSU_HALF: o_rdata = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default:  o_rdata = i_word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, word RAM access with sub-word read-modify-write.
// Optional LSU_MISALIGN_CHK_EN: flag misaligned/reserved-size requests instead of force-aligning them.
//
// state  | meaning
// IDLE   | ready for a request; captures it on handshake
// ACCESS | RAM addressed; load data registered or merged store word written
// RESP   | one-cycle completion pulse with load data / misalign flag
module lsu
  import type_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  LsuSize_e    req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_misalign_o,
  output MemAddrBus   mem_raddr_o,
  input  MemBus       mem_rdata_i,
  output MemAddrBus   mem_waddr_o,
  output MemBus       mem_wdata_o,
  output logic        mem_we_o
);

  LsuState_e   r_state;
  LsuState_e   w_state_nxt;
  logic        r_we;
  LsuSize_e    r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  MemAddrBus   r_word_addr;
  logic [31:0] r_wdata;
  logic        r_misalign;
  logic [31:0] r_resp_rdata;
  logic        r_resp_mis;

  logic        w_accept;
  logic [31:0] w_offset;
  MemAddrBus   w_word_addr;
  LsuSize_e    w_size_eff;
  logic [1:0]  w_lane;
  logic        w_misalign;
  MemBus       w_merged;
  logic [31:0] w_load;

  assign w_accept    = req_valid_i & req_ready_o;
  assign w_offset    = req_addr_i - BASE_ADDR;
  assign w_word_addr = MemAddrBus'(w_offset >> 2);

`ifdef LSU_MISALIGN_CHK_EN
  always_comb begin
    w_size_eff = req_size_i;
    w_lane     = req_addr_i[1:0];
    w_misalign = 1'b0;
    case (req_size_i)
      LSU_HALF: w_misalign = req_addr_i[0];
      LSU_WORD: w_misalign = |req_addr_i[1:0];
      LSU_RSVD: w_misalign = 1'b1;
      default:  w_misalign = 1'b0;
    endcase
  end
`else
  // Without checking, low address bits are dropped to the natural lane and size 11 acts as word.
  always_comb begin
    w_size_eff = LSU_WORD;
    w_lane     = 2'b00;
    w_misalign = 1'b0;
    case (req_size_i)
      LSU_BYTE: begin
        w_size_eff = LSU_BYTE;
        w_lane     = req_addr_i[1:0];
      end
      LSU_HALF: begin
        w_size_eff = LSU_HALF;
        w_lane     = {req_addr_i[1], 1'b0};
      end
      default: begin
        w_size_eff = LSU_WORD;
        w_lane     = 2'b00;
      end
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = ACCESS;
      ACCESS:  w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we         <= 1'b0;
      r_size       <= LSU_BYTE;
      r_unsigned   <= 1'b0;
      r_lane       <= 2'b00;
      r_word_addr  <= '0;
      r_wdata      <= '0;
      r_misalign   <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_mis   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we        <= req_we_i;
        r_size      <= w_size_eff;
        r_unsigned  <= req_unsigned_i;
        r_lane      <= w_lane;
        r_word_addr <= w_word_addr;
        r_wdata     <= req_wdata_i;
        r_misalign  <= w_misalign;
      end
      if (r_state == ACCESS) begin
        r_resp_rdata <= (r_we || r_misalign) ? 32'h0 : w_load;
        r_resp_mis   <= r_misalign;
      end
    end
  end

  lsu_align u_align (
    .i_word     (mem_rdata_i),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_lane     (r_lane),
    .i_unsigned (r_unsigned),
    .o_merged   (w_merged),
    .o_rdata    (w_load)
  );

  assign req_ready_o     = (r_state == IDLE) & rst_n;
  assign resp_valid_o    = (r_state == RESP);
  assign resp_rdata_o    = r_resp_rdata;
  assign resp_misalign_o = r_resp_mis;
  assign mem_raddr_o     = r_word_addr;
  assign mem_waddr_o     = r_word_addr;
  assign mem_wdata_o     = w_merged;
  // Reset asserted during ACCESS must kill the write in the same cycle.
  assign mem_we_o        = (r_state == ACCESS) & r_we & ~r_misalign & rst_n;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, hand sequences and random traffic vs a byte-level memory model.
module tb_lsu;
  import type_pkg::*;

`ifdef LSU_MISALIGN_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  LsuSize_e    req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_misalign_o;
  MemAddrBus   mem_raddr_o;
  MemBus       mem_rdata_i;
  MemAddrBus   mem_waddr_o;
  MemBus       mem_wdata_o;
  logic        mem_we_o;

  logic [31:0] ram [0:1023];
  logic [7:0]  ref_bytes [0:4095];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_we_i        (req_we_i),
    .req_size_i      (req_size_i),
    .req_unsigned_i  (req_unsigned_i),
    .req_addr_i      (req_addr_i),
    .req_wdata_i     (req_wdata_i),
    .resp_valid_o    (resp_valid_o),
    .resp_rdata_o    (resp_rdata_o),
    .resp_misalign_o (resp_misalign_o),
    .mem_raddr_o     (mem_raddr_o),
    .mem_rdata_i     (mem_rdata_i),
    .mem_waddr_o     (mem_waddr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_we_o        (mem_we_o)
  );

  assign mem_rdata_i = ram[mem_raddr_o];
  always @(posedge clk) if (mem_we_o) ram[mem_waddr_o] <= mem_wdata_o;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_mis;
    logic        exp_wr;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory; accesses resolved from size/alignment rules.
  function automatic void model(input logic we, input logic [1:0] sz, input logic un,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic mis, output logic wr);
    int n;
    int b;
    logic [31:0] v;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = CHK && ((sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00));
    b   = int'(a[11:0]);
    if (!CHK) b = b - (b % n);
    rd = 32'h0;
    wr = 1'b0;
    if (!mis) begin
      if (we) begin
        for (int i = 0; i < n; i++) ref_bytes[b + i] = wd[8*i +: 8];
        wr = 1'b1;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[b + i]) << (8 * i));
        if (!un && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        rd = v;
      end
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic rv, output logic [31:0] rd, output logic mis,
                        output logic wr, output logic [9:0] wa);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready_o && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_req", 32'(req_ready_o), 32'h1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = LsuSize_e'(sz);
    req_unsigned_i = un;
    req_addr_i     = a;
    req_wdata_i    = wd;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    wr = mem_we_o;
    wa = mem_waddr_o;
    @(posedge clk); #1;
    rv  = resp_valid_o;
    rd  = resp_rdata_o;
    mis = resp_misalign_o;
    chk("we_only_one_cycle", 32'(mem_we_o), 32'h0);
  endtask

  function automatic void add(input logic we, input logic [1:0] sz, input logic un,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] erd, input logic emis, input logic ewr);
    vec_t v;
    v.we = we; v.sz = sz; v.un = un; v.addr = a; v.wdata = wd;
    v.exp_rd = erd; v.exp_mis = emis; v.exp_wr = ewr;
    vt.push_back(v);
  endfunction

  initial begin
    logic        rv, mis, wr, m_mis, m_wr;
    logic [31:0] rd, m_rd, a, wd, exp_q;
    logic [9:0]  wa;
    logic [1:0]  sz;
    logic        we, un;
    int          k;

    for (int i = 0; i < 1024; i++) begin
      ram[i] = $urandom;
      for (int j = 0; j < 4; j++) ref_bytes[4*i + j] = ram[i][8*j +: 8];
    end

    rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = LSU_WORD;
    req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_low", 32'(req_ready_o), 32'h0);
    chk("reset_resp_valid", 32'(resp_valid_o), 32'h0);
    chk("reset_rdata", resp_rdata_o, 32'h0);
    chk("reset_misalign", 32'(resp_misalign_o), 32'h0);
    chk("reset_mem_we", 32'(mem_we_o), 32'h0);
    chk("reset_raddr", 32'(mem_raddr_o), 32'h0);
    chk("reset_waddr", 32'(mem_waddr_o), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(req_ready_o), 32'h1);

    add(1, 2'd2, 0, 32'h8, 32'hDEADBEEF, 32'h0, 0, 1);
    add(0, 2'd2, 0, 32'h8, 32'h0,        32'hDEADBEEF, 0, 0);
    add(1, 2'd2, 0, 32'h8, 32'h11223344, 32'h0, 0, 1);
    add(1, 2'd0, 0, 32'h9, 32'h1234565A, 32'h0, 0, 1);
    add(0, 2'd2, 0, 32'h8, 32'h0,        32'h11225A44, 0, 0);
    add(0, 2'd0, 0, 32'h9, 32'h0,        32'h0000005A, 0, 0);
    add(1, 2'd0, 0, 32'hB, 32'hFFFFFFF0, 32'h0, 0, 1);
    add(0, 2'd0, 0, 32'hB, 32'h0,        32'hFFFFFFF0, 0, 0);
    add(0, 2'd0, 1, 32'hB, 32'h0,        32'h000000F0, 0, 0);
    add(1, 2'd2, 0, 32'h4, 32'h0,        32'h0, 0, 1);
    add(1, 2'd1, 0, 32'h6, 32'hABCDBEEF, 32'h0, 0, 1);
    add(0, 2'd2, 0, 32'h4, 32'h0,        32'hBEEF0000, 0, 0);
    add(0, 2'd1, 0, 32'h6, 32'h0,        32'hFFFFBEEF, 0, 0);
    add(0, 2'd1, 1, 32'h6, 32'h0,        32'h0000BEEF, 0, 0);
    if (CHK) begin
      add(1, 2'd2, 0, 32'h5, 32'h12345678, 32'h0, 1, 0);
      add(0, 2'd2, 0, 32'h4, 32'h0,        32'hBEEF0000, 0, 0);
      add(0, 2'd3, 0, 32'h8, 32'h0,        32'h0, 1, 0);
      add(0, 2'd1, 0, 32'h9, 32'h0,        32'h0, 1, 0);
    end else begin
      add(1, 2'd2, 0, 32'h5, 32'h12345678, 32'h0, 0, 1);
      add(0, 2'd2, 0, 32'h4, 32'h0,        32'h12345678, 0, 0);
      add(0, 2'd3, 0, 32'h8, 32'h0,        32'hF0225A44, 0, 0);
      add(0, 2'd1, 0, 32'h9, 32'h0,        32'h00005A44, 0, 0);
    end

    foreach (vt[i]) begin
      model(vt[i].we, vt[i].sz, vt[i].un, vt[i].addr, vt[i].wdata, m_rd, m_mis, m_wr);
      do_req(vt[i].we, vt[i].sz, vt[i].un, vt[i].addr, vt[i].wdata, rv, rd, mis, wr, wa);
      chk($sformatf("vec%0d_resp_valid", i), 32'(rv), 32'h1);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      chk($sformatf("vec%0d_misalign", i), 32'(mis), 32'(vt[i].exp_mis));
      chk($sformatf("vec%0d_mem_we", i), 32'(wr), 32'(vt[i].exp_wr));
      if (vt[i].exp_wr) chk($sformatf("vec%0d_waddr", i), 32'(wa), vt[i].addr >> 2);
    end

    // Continuous valid: only requests presented in IDLE cycles are taken.
    k = 0;
    @(negedge clk);
    while (!req_ready_o && k < 8) begin
      @(negedge clk);
      k++;
    end
    exp_q = 32'h0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = LSU_WORD;
      req_unsigned_i = 1'b0; req_addr_i = 32'(c * 4);
      chk($sformatf("bp_ready_c%0d", c), 32'(req_ready_o), 32'((c % 3) == 0));
      chk($sformatf("bp_resp_valid_c%0d", c), 32'(resp_valid_o), 32'((c % 3) == 2));
      if ((c % 3) == 0) model(1'b0, 2'd2, 1'b0, 32'(c * 4), 32'h0, exp_q, m_mis, m_wr);
      if ((c % 3) == 2) chk($sformatf("bp_rdata_c%0d", c), resp_rdata_o, exp_q);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;

    // Reset during the ACCESS cycle of a store.
    @(negedge clk);
    chk("rst_seq_ready", 32'(req_ready_o), 32'h1);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_size_i = LSU_WORD;
    req_addr_i = 32'h10; req_wdata_i = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_access_we", 32'(mem_we_o), 32'h0);
    @(posedge clk); #1;
    chk("rst_resp_valid", 32'(resp_valid_o), 32'h0);
    chk("rst_ready", 32'(req_ready_o), 32'h0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_misalign", 32'(resp_misalign_o), 32'h0);
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    chk("rst_waddr", 32'(mem_waddr_o), 32'h0);
    chk("rst_ram_unchanged", ram[4], {ref_bytes[19], ref_bytes[18], ref_bytes[17], ref_bytes[16]});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", 32'(req_ready_o), 32'h1);
    chk("rst_release_resp", 32'(resp_valid_o), 32'h0);

    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      a  = ($urandom & 32'h0000_003F) | ($urandom_range(0, 1) ? 32'hABC0_0000 : 32'h0);
      wd = $urandom;
      model(we, sz, un, a, wd, m_rd, m_mis, m_wr);
      do_req(we, sz, un, a, wd, rv, rd, mis, wr, wa);
      chk($sformatf("rnd%0d_resp_valid", t), 32'(rv), 32'h1);
      chk($sformatf("rnd%0d_rdata", t), rd, m_rd);
      chk($sformatf("rnd%0d_misalign", t), 32'(mis), 32'(m_mis));
      chk($sformatf("rnd%0d_mem_we", t), 32'(wr), 32'(m_wr));
      if (m_wr) chk($sformatf("rnd%0d_waddr", t), 32'(wa), 32'(a[11:2]));
    end

    @(negedge clk);
    for (int w = 0; w < 1024; w++)
      chk($sformatf("ram_word%0d", w), ram[w],
          {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
